// File: rtl/sram_2p_march_bist_ctrl.sv
// March C- BIST engine for one port of a 2-port SRAM macro (drives the macro BIST mux pins).
// Optional first-failure diagnostics (FAIL_ADDR/FAIL_ELEM/FAIL_BITS) enabled by `define BIST_DIAG_EN.
module sram_2p_march_bist_ctrl #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic          FAIL,
  output logic          BIST_EN,
  output logic          BIST_MEN,
  output logic          BIST_WEN,
  output logic          BIST_REN,
  output logic [AW-1:0] BIST_ADDR,
  output logic [DW-1:0] BIST_DIN,
  output logic [DW-1:0] BIST_BM,
  input  logic [DW-1:0] BIST_DOUT
`ifdef BIST_DIAG_EN
  ,
  output logic [AW-1:0] FAIL_ADDR,
  output logic [2:0]    FAIL_ELEM,
  output logic [DW-1:0] FAIL_BITS
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  localparam int unsigned   CntW    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [AW-1:0] AddrTop = {AW{1'b1}};
  localparam logic [DW-1:0] Ones    = {DW{1'b1}};
  localparam logic [DW-1:0] Zeros   = {DW{1'b0}};

  state_e          state_q;
  logic [2:0]      elem_q;
  logic            op_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   exp_q;
  logic [CntW-1:0] drain_cnt_q;

  logic            pipe_vld_q  [READ_LAT];
  logic [DW-1:0]   pipe_exp_q  [READ_LAT];
`ifdef BIST_DIAG_EN
  logic [AW-1:0]   pipe_addr_q [READ_LAT];
  logic [2:0]      pipe_elem_q [READ_LAT];
`endif

  logic            elem_desc;
  logic            elem_single;
  logic            addr_end;
  logic            run_last;
  logic [2:0]      ld_elem;
  logic            ld_op;
  logic [AW-1:0]   ld_addr;
  logic            ld_rd;
  logic [DW-1:0]   ld_wdata;
  logic [DW-1:0]   ld_rexp;
  logic [DW-1:0]   cmp_exp;
  logic            mismatch;

  // Next op to present; from IDLE this is the first op of E0.
  always_comb begin
    elem_desc   = (elem_q == 3'd3) || (elem_q == 3'd4);
    elem_single = (elem_q == 3'd0) || (elem_q == 3'd5);
    addr_end    = elem_desc ? (addr_q == '0) : (addr_q == AddrTop);
    run_last    = (elem_q == 3'd5) && addr_end;
    ld_elem     = elem_q;
    ld_op       = 1'b0;
    ld_addr     = addr_q;
    if (state_q == StIdle) begin
      ld_elem = 3'd0;
      ld_addr = '0;
    end else if (!elem_single && !op_q) begin
      ld_op = 1'b1;
    end else if (addr_end) begin
      ld_elem = elem_q + 3'd1;
      ld_addr = ((ld_elem == 3'd3) || (ld_elem == 3'd4)) ? AddrTop : '0;
    end else if (elem_desc) begin
      ld_addr = addr_q - AW'(1);
    end else begin
      ld_addr = addr_q + AW'(1);
    end
    ld_rd    = (ld_elem == 3'd5) || ((ld_elem != 3'd0) && !ld_op);
    ld_wdata = ld_elem[0] ? Ones : Zeros;
    ld_rexp  = ((ld_elem == 3'd2) || (ld_elem == 3'd4)) ? Ones : Zeros;
  end

  // Written so that an X/Z on DOUT falls through to a mismatch.
  always_comb begin
    cmp_exp  = pipe_exp_q[READ_LAT-1];
    mismatch = 1'b1;
    if (BIST_DOUT == cmp_exp) begin
      mismatch = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      elem_q      <= 3'd0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      exp_q       <= '0;
      drain_cnt_q <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      FAIL        <= 1'b0;
      BIST_EN     <= 1'b0;
      BIST_MEN    <= 1'b0;
      BIST_WEN    <= 1'b0;
      BIST_REN    <= 1'b0;
      BIST_ADDR   <= '0;
      BIST_DIN    <= '0;
      BIST_BM     <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_exp_q[i] <= '0;
`ifdef BIST_DIAG_EN
        pipe_addr_q[i] <= '0;
        pipe_elem_q[i] <= 3'd0;
`endif
      end
`ifdef BIST_DIAG_EN
      FAIL_ADDR <= '0;
      FAIL_ELEM <= 3'd0;
      FAIL_BITS <= '0;
`endif
    end else begin
      pipe_vld_q[0] <= BIST_REN;
      pipe_exp_q[0] <= exp_q;
`ifdef BIST_DIAG_EN
      pipe_addr_q[0] <= addr_q;
      pipe_elem_q[0] <= elem_q;
`endif
      for (int i = 1; i < int'(READ_LAT); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_exp_q[i] <= pipe_exp_q[i-1];
`ifdef BIST_DIAG_EN
        pipe_addr_q[i] <= pipe_addr_q[i-1];
        pipe_elem_q[i] <= pipe_elem_q[i-1];
`endif
      end

      if (pipe_vld_q[READ_LAT-1] && mismatch) begin
        FAIL <= 1'b1;
`ifdef BIST_DIAG_EN
        if (!FAIL) begin
          FAIL_ADDR <= pipe_addr_q[READ_LAT-1];
          FAIL_ELEM <= pipe_elem_q[READ_LAT-1];
          FAIL_BITS <= BIST_DOUT ^ cmp_exp;
        end
`endif
      end

      unique case (state_q)
        StIdle: begin
          if (START) begin
            state_q <= StRun;
            BUSY    <= 1'b1;
            DONE    <= 1'b0;
            FAIL    <= 1'b0;
            BIST_EN <= 1'b1;
`ifdef BIST_DIAG_EN
            FAIL_ADDR <= '0;
            FAIL_ELEM <= 3'd0;
            FAIL_BITS <= '0;
`endif
          end
        end
        StRun: begin
          if (run_last) begin
            state_q     <= StDrain;
            drain_cnt_q <= '0;
          end
        end
        StDrain: begin
          if (drain_cnt_q == CntW'(READ_LAT - 1)) begin
            state_q <= StFin;
          end else begin
            drain_cnt_q <= drain_cnt_q + CntW'(1);
          end
        end
        StFin: begin
          state_q <= StIdle;
          BUSY    <= 1'b0;
          DONE    <= 1'b1;
          BIST_EN <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase

      // Present the next op on START or while the run continues; otherwise park the pins.
      if ((state_q == StIdle && START) || (state_q == StRun && !run_last)) begin
        elem_q    <= ld_elem;
        op_q      <= ld_op;
        addr_q    <= ld_addr;
        exp_q     <= ld_rd ? ld_rexp : Zeros;
        BIST_MEN  <= 1'b1;
        BIST_REN  <= ld_rd;
        BIST_WEN  <= !ld_rd;
        BIST_ADDR <= ld_addr;
        BIST_DIN  <= ld_rd ? Zeros : ld_wdata;
        BIST_BM   <= ld_rd ? Zeros : Ones;
      end else begin
        BIST_MEN  <= 1'b0;
        BIST_REN  <= 1'b0;
        BIST_WEN  <= 1'b0;
        BIST_ADDR <= '0;
        BIST_DIN  <= '0;
        BIST_BM   <= '0;
      end
    end
  end

endmodule
